// File: rtl/avr_tick_scheduler_pkg.sv
// Shared definitions for the tick scheduler: register offsets, I/O addresses,
// CTRL bit positions and small byte-packing helpers.
package avr_tick_scheduler_pkg;

  // The address map always reserves room for four channels.
  localparam int NCH_MAX = 4;

  // Register offset within a channel's 4-byte window (address 4c+offset).
  typedef enum logic [1:0] {
    REG_RLDL = 2'd0,
    REG_RLDH = 2'd1,
    REG_CNTL = 2'd2,
    REG_CNTH = 2'd3
  } reg_off_e;

  // Absolute addresses of the non-windowed registers.
  localparam logic [4:0] ADDR_CTRL  = 5'h10;
  localparam logic [4:0] ADDR_PENDR = 5'h14;
  localparam logic [4:0] ADDR_ACTV  = 5'h15;

  // CTRL register bit positions.
  localparam int CTRL_EN   = 7;
  localparam int CTRL_PER  = 6;
  localparam int CTRL_IE   = 5;
  localparam int CTRL_PEND = 0;

  // Assemble the CTRL readback byte from the individual flags.
  function automatic logic [7:0] pack_ctrl(input logic en, input logic per,
                                           input logic ie, input logic pend);
    logic [7:0] r;
    r = 8'h00;
    r[CTRL_EN]   = en;
    r[CTRL_PER]  = per;
    r[CTRL_IE]   = ie;
    r[CTRL_PEND] = pend;
    return r;
  endfunction

  // Assemble the ACTV readback byte.
  function automatic logic [7:0] pack_actv(input logic vld, input logic [1:0] idx);
    return {vld, 5'b00000, idx};
  endfunction

endpackage

// File: rtl/avr_tick_scheduler_if.sv
// AVR I/O bus plus interrupt request/acknowledge pair seen by the scheduler.
interface avr_tick_scheduler_if;
  logic       io_re;
  logic       io_we;
  logic [4:0] io_a;
  logic [7:0] io_di;
  logic [7:0] io_do;
  logic       irq;
  logic       ack;

  modport master (
    output io_re, io_we, io_a, io_di, ack,
    input  io_do, irq
  );

  modport slave (
    input  io_re, io_we, io_a, io_di, ack,
    output io_do, irq
  );
endinterface

// File: rtl/avr_tick_scheduler_channel.sv
// One software timer channel: reload value, down-counter, control flags and
// the pending flag. The top level does all address decoding.
module avr_tick_scheduler_channel
  import avr_tick_scheduler_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_i,
  input  logic          rld_lo_we_i,
  input  logic          rld_hi_we_i,
  input  logic          ctrl_we_i,
  input  logic [7:0]    wdata_i,
  input  logic          pend_clr_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] rld_o,
  output logic [7:0]    ctrl_o,
  output logic          pend_o,
  output logic          ie_o
);

  logic [CW-1:0] rld_q, rld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          per_q, per_d;
  logic          ie_q, ie_d;
  logic          pend_q, pend_d;
  logic          fire;

  // Next-state: register writes, then counting in priority order
  // (enable edge, stop, expiry, decrement); a fire beats any pending clear.
  always_comb begin
    rld_d  = rld_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    per_d  = per_q;
    ie_d   = ie_q;
    fire   = 1'b0;

    if (rld_lo_we_i) rld_d[7:0]    = wdata_i;
    if (rld_hi_we_i) rld_d[CW-1:8] = wdata_i[CW-9:0];

    if (ctrl_we_i) begin
      en_d  = wdata_i[CTRL_EN];
      per_d = wdata_i[CTRL_PER];
      ie_d  = wdata_i[CTRL_IE];
    end

    if (ctrl_we_i && wdata_i[CTRL_EN] && !en_q) begin
      // Fresh start: load the period, ignore any tick in this cycle.
      cnt_d = rld_q;
    end else if (ctrl_we_i && !wdata_i[CTRL_EN]) begin
      // Stopped: counter holds its value.
      cnt_d = cnt_q;
    end else if (tick_i && en_q) begin
      if (cnt_q <= CW'(1)) begin
        fire = 1'b1;
        if (per_q) begin
          cnt_d = rld_q;
        end else begin
          cnt_d = '0;
          en_d  = 1'b0;
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    pend_d = (pend_q & ~pend_clr_i) | fire;
  end

  // Channel state flops, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rld_q  <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      per_q  <= 1'b0;
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      rld_q  <= rld_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      per_q  <= per_d;
      ie_q   <= ie_d;
      pend_q <= pend_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign rld_o  = rld_q;
  assign ctrl_o = pack_ctrl(en_q, per_q, ie_q, pend_q);
  assign pend_o = pend_q;
  assign ie_o   = ie_q;

endmodule

// File: rtl/avr_tick_scheduler.sv
// Software timer multiplexer on top of the systick overflow strobe: NCH
// channels, shared irq, fixed-priority ACTV selection and ack retirement.
module avr_tick_scheduler
  import avr_tick_scheduler_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  avr_tick_scheduler_if.slave bus
);

  // Bit c set when channel c physically exists.
  localparam logic [NCH_MAX-1:0] CH_MASK = 4'((1 << NCH) - 1);

  logic                         wr;
  logic [NCH_MAX-1:0][CW-1:0]   cnt_w;
  logic [NCH_MAX-1:0][CW-1:0]   rld_w;
  logic [NCH_MAX-1:0][7:0]      ctrl_w;
  logic [NCH_MAX-1:0]           pend_w;
  logic [NCH_MAX-1:0]           ie_w;
  logic [NCH_MAX-1:0]           pend_clr;
  logic [NCH_MAX-1:0]           rld_lo_we;
  logic [NCH_MAX-1:0]           rld_hi_we;
  logic [NCH_MAX-1:0]           ctrl_we;
  logic                         act_vld;
  logic [1:0]                   act_idx;
  logic [7:0]                   ctmp_q, ctmp_d;
  logic [7:0]                   rdata;

  // A simultaneous read wins over a write.
  assign wr = bus.io_we & ~bus.io_re;

  // Lowest-index channel that is both pending and interrupt-enabled.
  always_comb begin
    act_vld = 1'b0;
    act_idx = 2'd0;
    for (int c = NCH_MAX - 1; c >= 0; c--) begin
      if (pend_w[c] && ie_w[c]) begin
        act_vld = 1'b1;
        act_idx = 2'(c);
      end
    end
  end

  // Per-channel write strobes and pending-clear requests (W1C or ack).
  always_comb begin
    rld_lo_we = '0;
    rld_hi_we = '0;
    ctrl_we   = '0;
    pend_clr  = '0;
    for (int c = 0; c < NCH_MAX; c++) begin
      rld_lo_we[c] = wr && CH_MASK[c] && (bus.io_a == 5'(4 * c));
      rld_hi_we[c] = wr && CH_MASK[c] && (bus.io_a == 5'(4 * c + 1));
      ctrl_we[c]   = wr && CH_MASK[c] && (bus.io_a == ADDR_CTRL + 5'(c));
      pend_clr[c]  = (wr && (bus.io_a == ADDR_PENDR) && bus.io_di[c]) ||
                     (bus.ack && act_vld && (act_idx == 2'(c)));
    end
  end

  for (genvar g = 0; g < NCH_MAX; g++) begin : g_ch
    if (g < NCH) begin : g_on
      avr_tick_scheduler_channel #(.CW(CW)) u_ch (
        .clk         (clk),
        .rst         (rst),
        .tick_i      (tick),
        .rld_lo_we_i (rld_lo_we[g]),
        .rld_hi_we_i (rld_hi_we[g]),
        .ctrl_we_i   (ctrl_we[g]),
        .wdata_i     (bus.io_di),
        .pend_clr_i  (pend_clr[g]),
        .cnt_o       (cnt_w[g]),
        .rld_o       (rld_w[g]),
        .ctrl_o      (ctrl_w[g]),
        .pend_o      (pend_w[g]),
        .ie_o        (ie_w[g])
      );
    end else begin : g_off
      assign cnt_w[g]  = '0;
      assign rld_w[g]  = '0;
      assign ctrl_w[g] = '0;
      assign pend_w[g] = 1'b0;
      assign ie_w[g]   = 1'b0;
    end
  end

  // CNTL read captures the counter's upper bits so CNTH returns a coherent pair.
  always_comb begin
    ctmp_d = ctmp_q;
    if (bus.io_re && !bus.io_a[4] && (bus.io_a[1:0] == REG_CNTL) &&
        CH_MASK[bus.io_a[3:2]]) begin
      ctmp_d = 8'(cnt_w[bus.io_a[3:2]][CW-1:8]);
    end
  end

  // Shared high-byte snapshot register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctmp_q <= 8'h00;
    else     ctmp_q <= ctmp_d;
  end

  // Read data mux; zero whenever no read is in progress or the address is unmapped.
  always_comb begin
    rdata = 8'h00;
    if (bus.io_re) begin
      if (!bus.io_a[4]) begin
        if (CH_MASK[bus.io_a[3:2]]) begin
          case (reg_off_e'(bus.io_a[1:0]))
            REG_RLDL: rdata = rld_w[bus.io_a[3:2]][7:0];
            REG_RLDH: rdata = 8'(rld_w[bus.io_a[3:2]][CW-1:8]);
            REG_CNTL: rdata = cnt_w[bus.io_a[3:2]][7:0];
            REG_CNTH: rdata = ctmp_q;
            default:  rdata = 8'h00;
          endcase
        end
      end else if (bus.io_a[3:2] == 2'b00) begin
        if (CH_MASK[bus.io_a[1:0]]) rdata = ctrl_w[bus.io_a[1:0]];
      end else if (bus.io_a == ADDR_PENDR) begin
        rdata = {4'b0000, pend_w};
      end else if (bus.io_a == ADDR_ACTV) begin
        rdata = pack_actv(act_vld, act_idx);
      end
    end
  end

  assign bus.io_do = rdata;
  assign bus.irq   = |(pend_w & ie_w);

endmodule

// File: tb/tb_avr_tick_scheduler.sv
// Directed bench for avr_tick_scheduler with hand-computed expectations.
module tb_avr_tick_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  int   total = 0;
  int   bad = 0;

  avr_tick_scheduler_if bus();

  avr_tick_scheduler #(.NCH(4), .CW(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.io_we = 1'b1;
    bus.io_a  = a;
    bus.io_di = d;
    step();
    bus.io_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic tk, output logic [7:0] d);
    bus.io_re = 1'b1;
    bus.io_a  = a;
    tick      = tk;
    #1;
    d = bus.io_do;
    step();
    bus.io_re = 1'b0;
    tick      = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  logic [7:0] d, lo, hi;

  initial begin
    bus.io_re = 1'b0;
    bus.io_we = 1'b0;
    bus.io_a  = 5'h00;
    bus.io_di = 8'h00;
    bus.ack   = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_irq", 16'(bus.irq), 16'h0);
    chk("rst_do_idle", 16'(bus.io_do), 16'h0);
    rd(5'h14, 1'b0, d); chk("rst_pendr", 16'(d), 16'h00);
    rd(5'h15, 1'b0, d); chk("rst_actv", 16'(d), 16'h00);
    rd(5'h10, 1'b0, d); chk("rst_ctrl0", 16'(d), 16'h00);

    // ch0 periodic, RELOAD=3
    wr(5'h00, 8'h03);
    wr(5'h01, 8'h00);
    wr(5'h10, 8'hE0);
    rd(5'h02, 1'b0, d); chk("p_cnt_start", 16'(d), 16'h03);
    for (int k = 1; k <= 10; k++) begin
      do_tick();
      chk($sformatf("p_irq_t%0d", k), 16'(bus.irq), (k % 3 == 0) ? 16'h1 : 16'h0);
      rd(5'h14, 1'b0, d);
      chk($sformatf("p_pend_t%0d", k), 16'(d), (k % 3 == 0) ? 16'h01 : 16'h00);
      rd(5'h02, 1'b0, d);
      chk($sformatf("p_cnt_t%0d", k), 16'(d), (k % 3 == 0) ? 16'h3 : 16'(3 - (k % 3)));
      if (k % 3 == 0) begin
        rd(5'h15, 1'b0, d); chk($sformatf("p_actv_t%0d", k), 16'(d), 16'h80);
        wr(5'h14, 8'h01);
      end
    end
    wr(5'h10, 8'h00);
    rd(5'h10, 1'b0, d); chk("p_ctrl_off", 16'(d), 16'h00);

    // ch1 one-shot, RELOAD=2
    wr(5'h04, 8'h02);
    wr(5'h05, 8'h00);
    wr(5'h11, 8'hA0);
    do_tick();
    rd(5'h14, 1'b0, d); chk("os_pend_t1", 16'(d), 16'h00);
    do_tick();
    rd(5'h14, 1'b0, d); chk("os_pend_t2", 16'(d), 16'h02);
    rd(5'h11, 1'b0, d); chk("os_ctrl_t2", 16'(d), 16'h21);
    rd(5'h15, 1'b0, d); chk("os_actv", 16'(d), 16'h81);
    wr(5'h14, 8'h02);
    for (int k = 3; k <= 5; k++) do_tick();
    rd(5'h14, 1'b0, d); chk("os_pend_t5", 16'(d), 16'h00);
    rd(5'h11, 1'b0, d); chk("os_ctrl_t5", 16'(d), 16'h20);
    rd(5'h06, 1'b0, d); chk("os_cnt_t5", 16'(d), 16'h00);
    wr(5'h11, 8'h01);
    rd(5'h11, 1'b0, d); chk("ctrl_bit0_ro", 16'(d), 16'h00);

    // ch0 and ch2 fire together; ack retires lowest first
    wr(5'h00, 8'h01);
    wr(5'h08, 8'h01);
    wr(5'h09, 8'h00);
    wr(5'h10, 8'hA0);
    wr(5'h12, 8'hA0);
    do_tick();
    chk("arb_irq", 16'(bus.irq), 16'h1);
    rd(5'h15, 1'b0, d); chk("arb_actv0", 16'(d), 16'h80);
    do_ack();
    rd(5'h15, 1'b0, d); chk("arb_actv2", 16'(d), 16'h82);
    do_ack();
    chk("arb_irq_off", 16'(bus.irq), 16'h0);
    rd(5'h15, 1'b0, d); chk("arb_actv_none", 16'(d), 16'h00);
    rd(5'h14, 1'b0, d); chk("arb_pendr", 16'(d), 16'h00);

    // Fire and W1C on the same bit in the same clk: set wins
    wr(5'h10, 8'hE0);
    bus.io_we = 1'b1;
    bus.io_a  = 5'h14;
    bus.io_di = 8'h01;
    tick      = 1'b1;
    step();
    bus.io_we = 1'b0;
    tick      = 1'b0;
    rd(5'h14, 1'b0, d); chk("setwins_pend", 16'(d), 16'h01);
    wr(5'h14, 8'h01);
    rd(5'h14, 1'b0, d); chk("w1c_clear", 16'(d), 16'h00);
    wr(5'h10, 8'h00);

    // Atomic 16-bit counter read across a byte boundary while ticking
    wr(5'h0C, 8'h01);
    wr(5'h0D, 8'h02);
    rd(5'h0C, 1'b0, d); chk("rldl3", 16'(d), 16'h01);
    rd(5'h0D, 1'b0, d); chk("rldh3", 16'(d), 16'h02);
    wr(5'h13, 8'hC0);
    do_tick();
    rd(5'h0E, 1'b1, lo);
    rd(5'h0F, 1'b1, hi);
    chk("atomic_cnt_a", {hi, lo}, 16'h0200);
    rd(5'h0E, 1'b0, lo);
    rd(5'h0F, 1'b0, hi);
    chk("atomic_cnt_b", {hi, lo}, 16'h01FE);
    rd(5'h18, 1'b0, d); chk("unmapped_rd", 16'(d), 16'h00);

    // Asynchronous reset mid-run
    wr(5'h00, 8'h00);
    wr(5'h10, 8'hA0);
    do_tick();
    chk("pre_rst_irq", 16'(bus.irq), 16'h1);
    rd(5'h13, 1'b0, d); chk("pre_rst_ctrl3", 16'(d), 16'hC0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_irq", 16'(bus.irq), 16'h0);
    bus.io_re = 1'b1;
    bus.io_a  = 5'h13;
    #1;
    chk("arst_ctrl3", 16'(bus.io_do), 16'h00);
    bus.io_a = 5'h14;
    #1;
    chk("arst_pendr", 16'(bus.io_do), 16'h00);
    bus.io_re = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    do_tick();
    chk("post_rst_irq", 16'(bus.irq), 16'h0);
    rd(5'h15, 1'b0, d); chk("post_rst_actv", 16'(d), 16'h00);
    rd(5'h0E, 1'b0, d); chk("post_rst_cnt3", 16'(d), 16'h00);
    rd(5'h0C, 1'b0, d); chk("post_rst_rld3", 16'(d), 16'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
